window_blur: RTL
================

WINDOW_BLUR -- requirements
Module: window_blur

Interface
REQ-001 SHALL have parameter dataWidth, default 8: bits per pixel.
REQ-002 SHALL have parameter kernelWidth, default 3: window columns.
REQ-003 SHALL have parameter kernelHeight, default 3: window rows.
REQ-004 SHALL have parameter imageWidth, default 512: output pixels per line.
REQ-005 SHALL have parameter fifoDepth, default 8: output FIFO entries, power of two, at least 4.
REQ-006 SHALL have port i_clk, input, 1: the single clock; all logic on its rising edge.
REQ-007 SHALL have port i_reset_n, input, 1: reset, synchronous and active-low.
REQ-008 SHALL have port i_window, input, kernelWidth*kernelHeight*dataWidth: window bus, pixel r,c at bits [(r*kernelWidth+c)*dataWidth +: dataWidth].
REQ-009 SHALL have port i_window_valid, input, 1: i_window valid this cycle; no backpressure to the source.
REQ-010 SHALL have port o_pixel_data, output, dataWidth: blurred pixel at the FIFO head.
REQ-011 SHALL have port o_pixel_data_valid, output, 1: o_pixel_data valid.
REQ-012 SHALL have port i_pixel_ready, input, 1: downstream accepts o_pixel_data.
REQ-013 SHALL have port o_eol, output, 1: the current output pixel is the last of its line.
REQ-014 SHALL have port o_almost_full, output, 1: upstream throttle hint.
REQ-015 SHALL have port o_overflow, output, 1: sticky flag, result dropped.

Function
REQ-016 SHALL sum all K=kernelWidth*kernelHeight window pixels, unsigned, with sum width dataWidth+clog2(K) (12 bits for 3x3), so no overflow occurs.
REQ-017 SHALL compute pixel = (sum*RECIP + 2^15) >> 16, with RECIP = round(2^16/K) (7282 for 3x3).
REQ-018 SHALL saturate the result to 2^dataWidth-1.
REQ-019 SHALL be a 3-stage pipeline: S1 registers the sum, S2 registers the product, S3 rounds, saturates and writes the FIFO. Each stage carries its own valid bit.
REQ-020 SHALL make o_pixel_data_valid high in cycle t+3 for a window valid in cycle t, when the FIFO is empty (first-word fall-through).
REQ-021 SHALL accept one window per cycle continuously; the pipeline never stalls.
REQ-022 SHALL complete an output handshake in a cycle with o_pixel_data_valid & i_pixel_ready; the FIFO then pops its head.
REQ-023 SHALL hold o_pixel_data and o_eol stable while o_pixel_data_valid is high and i_pixel_ready is low.
REQ-024 SHALL perform both operations when an S3 write and a pop coincide with the FIFO full; occupancy stays fifoDepth and nothing is dropped.
REQ-025 SHALL drop an S3 write that arrives with the FIFO full and no pop, and set o_overflow, which holds until reset.
REQ-026 SHALL clear o_pixel_data_valid when the last entry pops and no write occurs in that cycle. A write to an empty FIFO is visible in the next cycle.
REQ-027 SHALL drive o_almost_full combinationally high when FIFO occupancy plus valid S1/S2 entries is at least fifoDepth-3.
REQ-028 SHALL advance a column counter 0..imageWidth-1 on each output handshake, wrapping to 0 after imageWidth-1.
REQ-029 SHALL assert o_eol while o_pixel_data_valid is high and the column counter equals imageWidth-1.
REQ-030 SHALL keep the column counter unchanged by dropped results.

Reset
REQ-031 SHALL, while i_reset_n is low at a rising edge, clear the pipeline valids, FIFO pointers and occupancy, column counter and o_overflow.
REQ-032 SHALL drive o_pixel_data_valid=0, o_eol=0, o_almost_full=0 and o_overflow=0 after reset; o_pixel_data is 0 after reset.
REQ-033 SHALL, on reset mid-operation, discard all in-flight and buffered pixels. The first window valid after reset release produces the first output 3 cycles later.

Verification
REQ-034 SHALL cover: all nine pixels = 9, one valid cycle, ready high -> o_pixel_data=9 with valid exactly 3 cycles later.
REQ-035 SHALL cover: window sums 13, 14 and 2295 (all 255) -> outputs 1, 2 and 255; no wrap, no saturation error.
REQ-036 SHALL cover: ready low, 8 consecutive windows -> o_almost_full asserted once occupancy plus in-flight reaches 5; all 8 outputs held in order; o_overflow stays 0.
REQ-037 SHALL cover: ready low, 9 windows -> 9th result dropped, o_overflow=1 and sticky; then ready high -> exactly 8 pixels drain in order.
REQ-038 SHALL cover: FIFO full, S3 write and pop in the same cycle -> no drop, occupancy stays 8, output order preserved.
REQ-039 SHALL cover: imageWidth=4, 10 handshakes -> o_eol on pixels 4 and 8 only; reset asserted mid-stream -> all outputs 0 next cycle and the counter restarts at 0.

Source files
------------

// File: rtl/window_blur.sv
// window_blur: 3-stage box-filter datapath (sum, reciprocal multiply,
// round/saturate) feeding a first-word-fall-through output FIFO with
// line-end tagging, an almost-full hint for upstream and a sticky overflow flag.
module window_blur #(
  parameter int dataWidth    = 8,
  parameter int kernelWidth  = 3,
  parameter int kernelHeight = 3,
  parameter int imageWidth   = 512,
  parameter int fifoDepth    = 8
) (
  input  logic                                          i_clk,
  input  logic                                          i_reset_n,
  input  logic [kernelWidth*kernelHeight*dataWidth-1:0] i_window,
  input  logic                                          i_window_valid,
  output logic [dataWidth-1:0]                          o_pixel_data,
  output logic                                          o_pixel_data_valid,
  input  logic                                          i_pixel_ready,
  output logic                                          o_eol,
  output logic                                          o_almost_full,
  output logic                                          o_overflow
);

  localparam int K      = kernelWidth * kernelHeight;
  localparam int SW     = dataWidth + $clog2(K);
  // product of sum and a 17-bit-max reciprocal; the rounding add cannot carry out
  localparam int PW     = SW + 17;
  localparam int RECIP  = (65536 + K / 2) / K;
  localparam int STAGES = 2;
  localparam int AW     = $clog2(fifoDepth);
  localparam int CW     = AW + 1;
  localparam int XW     = (imageWidth > 1) ? $clog2(imageWidth) : 1;

  localparam logic [PW-1:0] SAT    = {{(PW-dataWidth){1'b0}}, {dataWidth{1'b1}}};
  localparam logic [PW-1:0] HALF   = PW'(32768);
  localparam logic [PW-1:0] RECIPW = PW'(RECIP);
  localparam logic [XW-1:0] LASTC  = XW'(imageWidth - 1);
  localparam logic [CW-1:0] DEPTH  = CW'(fifoDepth);
  localparam logic [CW-1:0] AFULL  = CW'(fifoDepth - 3);

  logic [K-1:0][dataWidth-1:0] pix;
  logic [STAGES:1]             vld_pipe;
  logic [SW-1:0]               sum_c, sum_q;
  logic [PW-1:0]               prod_q, rnd, shr;
  logic [dataWidth-1:0]        res;

  logic [dataWidth-1:0]        mem [fifoDepth];
  logic [AW-1:0]               wr_ptr, rd_ptr;
  logic [CW-1:0]               count;
  logic [XW-1:0]               col;
  logic                        full, push, pop, drop;

  assign pix = i_window;

  // adder over all window pixels; width is sized so the sum never wraps
  always_comb begin
    sum_c = '0;
    for (int i = 0; i < K; i++) sum_c = sum_c + SW'(pix[i]);
  end

  // stage valids advance every cycle; the pipeline never stalls
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) vld_pipe <= '0;
    else            vld_pipe <= {vld_pipe[STAGES-1:1], i_window_valid};
  end

  // S1 sum and S2 reciprocal product; datapath needs no reset, valids gate it
  always_ff @(posedge i_clk) begin
    sum_q  <= sum_c;
    prod_q <= PW'(sum_q) * RECIPW;
  end

  // S3: round to nearest, drop the 16 fraction bits, clamp to full scale
  always_comb begin
    rnd = prod_q + HALF;
    shr = rnd >> 16;
    res = (shr > SAT) ? SAT[dataWidth-1:0] : shr[dataWidth-1:0];
  end

  assign full = (count == DEPTH);
  assign pop  = o_pixel_data_valid & i_pixel_ready;
  // a pop in the same cycle frees the slot, so full+pop still accepts the write
  assign push = vld_pipe[STAGES] & (~full | pop);
  assign drop = vld_pipe[STAGES] & full & ~pop;

  // FIFO storage write
  always_ff @(posedge i_clk) begin
    if (push) mem[wr_ptr] <= res;
  end

  // FIFO pointers and occupancy; pointers wrap naturally (depth is 2^n)
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // sticky overflow: any result lost to a full FIFO is remembered until reset
  always_ff @(posedge i_clk) begin
    if (!i_reset_n)  o_overflow <= 1'b0;
    else if (drop)   o_overflow <= 1'b1;
  end

  // column position of the FIFO head; only real handshakes advance it
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) col <= '0;
    else if (pop)   col <= (col == LASTC) ? '0 : col + 1'b1;
  end

  assign o_pixel_data_valid = (count != '0);
  // gate the head so the bus reads zero whenever nothing is buffered
  assign o_pixel_data  = o_pixel_data_valid ? mem[rd_ptr] : '0;
  assign o_eol         = o_pixel_data_valid & (col == LASTC);
  // count in-flight S1/S2 work too: those results will land regardless
  assign o_almost_full = (count + CW'(vld_pipe[1]) + CW'(vld_pipe[STAGES])) >= AFULL;

endmodule
